// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port, reset-time clear sweep.
// Storage is split into one byte-wide bank per write lane.

module dual_port_ram_lane #(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  raddr_ok,
    output logic [7:0]            rdata
);
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_word;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Write-first forwards only this lane's new byte; disabled lanes fall back to the stored byte.
    always_comb begin
        rd_word = '0;
        if (raddr_ok) rd_word = mem[raddr];
        if (RDW_MODE == 1 && we && waddr == raddr) rd_word = wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= rd_word;
    end
endmodule

module dual_port_ram #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DEPTH      = 16,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_done,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid
);
    localparam int                  NUM_LANES = DATA_WIDTH / 8;
    localparam int                  STAGES    = 0;
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_W    = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ONE_W     = (ADDR_WIDTH + 1)'(1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                        state, state_nxt;
    logic [ADDR_WIDTH:0]           sweep_cnt;
    logic                          sweeping, run;
    logic                          wr_ok, rd_go, rd_in_range;
    logic [ADDR_WIDTH-1:0]         mem_waddr;
    logic [NUM_LANES-1:0][7:0]     wdata_l, rdata_l;
    logic [NUM_LANES-1:0]          lane_we;
    logic [STAGES:0]               vld_pipe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_INIT;
            sweep_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) sweep_cnt <= sweep_cnt + ONE_W;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (sweep_cnt == LAST_W) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        init_done = (state == S_RUN);
        run       = (state == S_RUN);
        sweeping  = (state == S_INIT) && rst_n;
    end

    // Out-of-range writes are dropped outright so shallow configurations never alias.
    always_comb begin
        wr_ok       = run && wr_en && ({1'b0, wr_addr} < DEPTH_W);
        rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
        rd_go       = run && rd_en;
        mem_waddr   = sweeping ? sweep_cnt[ADDR_WIDTH-1:0] : wr_addr;
        wdata_l     = sweeping ? INIT_VALUE : wr_data;
        lane_we     = sweeping ? '1 : (wr_ok ? wr_be : '0);
    end

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            dual_port_ram_lane #(
                .ADDR_WIDTH(ADDR_WIDTH),
                .DEPTH     (DEPTH),
                .RDW_MODE  (RDW_MODE)
            ) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .we      (lane_we[i]),
                .waddr   (mem_waddr),
                .wdata   (wdata_l[i]),
                .re      (rd_go),
                .raddr   (rd_addr),
                .raddr_ok(rd_in_range),
                .rdata   (rdata_l[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= rd_go;
    end

    assign rd_valid = vld_pipe[STAGES];
    assign rd_data  = rdata_l;
endmodule
